// File: rtl/pong_pkg.sv
// Shared definitions for the pong drawing path: screen geometry, palette and the fill FSM encoding.
package pong_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam logic [2:0] COL_BLACK = 3'b000;
  localparam logic [2:0] COL_RED   = 3'b100;
  localparam logic [2:0] COL_WHITE = 3'b111;

  // Width of a requester index; covers up to 8 requesters.
  localparam int GIDW = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    DRAW  = 2'd2,
    DONE  = 2'd3
  } fill_state_t;

endpackage

// File: rtl/rect_fill_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector; returns the first asserted request at or after ptr, wrapping.
module rr_pick
  import pong_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req,
  input  logic [GIDW-1:0] ptr,
  output logic [GIDW-1:0] idx,
  output logic            valid
);

  // Padding to a full 2^GIDW vector lets the search index it without width games.
  logic [7:0] req_pad;
  assign req_pad = 8'(req);

  always_comb begin
    logic [GIDW-1:0] cand;
    // NOTE: every combinational output gets a default before any branch, so no path leaves it unassigned (no latch).
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = GIDW'((int'(ptr) + i) % NREQ);
      if (!valid && req_pad[cand]) begin
        idx   = cand;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rect_fill_arbiter.sv
// rect_fill_arbiter: shares the VGA write port among NREQ clients, filling one solid rectangle per grant.
// Define RECT_CLIP_EN to suppress plots that fall outside SCREEN_W x SCREEN_H (the cycle is still spent).
module rect_fill_arbiter #(
  parameter int NREQ     = 4,
  parameter int XW       = 8,
  parameter int YW       = 8,
  parameter int CW       = 3,
  parameter int SCREEN_W = pong_pkg::SCREEN_W,
  parameter int SCREEN_H = pong_pkg::SCREEN_H
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*XW-1:0]        rect_x,
  input  logic [NREQ*YW-1:0]        rect_y,
  input  logic [NREQ*XW-1:0]        rect_w,
  input  logic [NREQ*YW-1:0]        rect_h,
  input  logic [NREQ*CW-1:0]        rect_colour,
  output logic [NREQ-1:0]           done,
  output logic                      busy,
  output logic [pong_pkg::GIDW-1:0] grant_id,
  output logic [XW-1:0]             vga_x,
  output logic [YW-1:0]             vga_y,
  output logic [CW-1:0]             vga_colour,
  output logic                      vga_plot
);
  import pong_pkg::*;

  if (NREQ < 2 || NREQ > 8 || SCREEN_W > (1 << XW) || SCREEN_H > (1 << YW)) begin : g_bad_cfg
    $error("rect_fill_arbiter: unsupported parameter set");
  end

  fill_state_t     state_q, state_d;
  logic [GIDW-1:0] ptr_q, grant_q;
  logic [GIDW-1:0] win_idx;
  logic            win_valid;

  logic [XW-1:0]   x0_q, w_q, cx_q;
  logic [YW-1:0]   y0_q, h_q, cy_q;
  logic [CW-1:0]   col_q;
  logic [XW-1:0]   hold_x_q;
  logic [YW-1:0]   hold_y_q;
  logic [CW-1:0]   hold_c_q;

  // Per-requester views of the flat rect buses, padded to 8 entries for a full-width index.
  logic [XW-1:0]   rx_arr [8];
  logic [YW-1:0]   ry_arr [8];
  logic [XW-1:0]   rw_arr [8];
  logic [YW-1:0]   rh_arr [8];
  logic [CW-1:0]   rc_arr [8];

  for (genvar i = 0; i < 8; i++) begin : g_unpack
    if (i < NREQ) begin : g_used
      assign rx_arr[i] = rect_x[i*XW +: XW];
      assign ry_arr[i] = rect_y[i*YW +: YW];
      assign rw_arr[i] = rect_w[i*XW +: XW];
      assign rh_arr[i] = rect_h[i*YW +: YW];
      assign rc_arr[i] = rect_colour[i*CW +: CW];
    end else begin : g_pad
      assign rx_arr[i] = '0;
      assign ry_arr[i] = '0;
      assign rw_arr[i] = '0;
      assign rh_arr[i] = '0;
      assign rc_arr[i] = '0;
    end
  end

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .idx   (win_idx),
    .valid (win_valid)
  );

  logic          sel_empty;
  logic          last_pix;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic          pix_ok;

  assign sel_empty = (rw_arr[win_idx] == '0) || (rh_arr[win_idx] == '0);
  assign last_pix  = (cx_q == w_q - XW'(1)) && (cy_q == h_q - YW'(1));

`ifdef RECT_CLIP_EN
  // One extra bit keeps the carry, so a wrapped coordinate is rejected along with off-screen ones.
  logic [XW:0] sum_x;
  logic [YW:0] sum_y;
  assign sum_x  = {1'b0, x0_q} + {1'b0, cx_q};
  assign sum_y  = {1'b0, y0_q} + {1'b0, cy_q};
  assign pix_x  = sum_x[XW-1:0];
  assign pix_y  = sum_y[YW-1:0];
  assign pix_ok = (sum_x < (XW+1)'(SCREEN_W)) && (sum_y < (YW+1)'(SCREEN_H));
`else
  assign pix_x  = x0_q + cx_q;
  assign pix_y  = y0_q + cy_q;
  assign pix_ok = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (|req) state_d = LATCH;
      LATCH: begin
        if (!win_valid)     state_d = IDLE;
        else if (sel_empty) state_d = DONE;
        else                state_d = DRAW;
      end
      DRAW:  if (last_pix) state_d = DONE;
      DONE:  state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses <= only, so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      grant_q  <= '0;
      x0_q     <= '0;
      y0_q     <= '0;
      w_q      <= '0;
      h_q      <= '0;
      col_q    <= '0;
      cx_q     <= '0;
      cy_q     <= '0;
      hold_x_q <= '0;
      hold_y_q <= '0;
      hold_c_q <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        LATCH: begin
          if (win_valid) begin
            grant_q <= win_idx;
            x0_q    <= rx_arr[win_idx];
            y0_q    <= ry_arr[win_idx];
            w_q     <= rw_arr[win_idx];
            h_q     <= rh_arr[win_idx];
            col_q   <= rc_arr[win_idx];
          end
          cx_q <= '0;
          cy_q <= '0;
        end
        DRAW: begin
          if (cx_q == w_q - XW'(1)) begin
            cx_q <= '0;
            cy_q <= cy_q + YW'(1);
          end else begin
            cx_q <= cx_q + XW'(1);
          end
        end
        DONE:    ptr_q <= (grant_q == GIDW'(NREQ - 1)) ? '0 : grant_q + GIDW'(1);
        default: ;
      endcase
      // Remember the last pixel actually written so the port holds it between plots.
      if (vga_plot) begin
        hold_x_q <= pix_x;
        hold_y_q <= pix_y;
        hold_c_q <= col_q;
      end
    end
  end

  assign vga_plot   = (state_q == DRAW) && pix_ok;
  assign vga_x      = vga_plot ? pix_x : hold_x_q;
  assign vga_y      = vga_plot ? pix_y : hold_y_q;
  assign vga_colour = vga_plot ? col_q : hold_c_q;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE) ? NREQ'(1 << grant_q) : '0;
  assign grant_id   = (state_q == LATCH && win_valid) ? win_idx : grant_q;

endmodule

// File: tb/tb_rect_fill_arbiter.sv
// Self-checking bench for rect_fill_arbiter: directed cases plus randomized rectangles against a raster/RR model.
module tb_rect_fill_arbiter;
  import pong_pkg::*;

  localparam int NREQ = 4;
  localparam int XW   = 8;
  localparam int YW   = 8;
  localparam int CW   = 3;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req;
  logic [NREQ*XW-1:0]   rect_x, rect_w;
  logic [NREQ*YW-1:0]   rect_y, rect_h;
  logic [NREQ*CW-1:0]   rect_colour;
  logic [NREQ-1:0]      done;
  logic                 busy;
  logic [2:0]           grant_id;
  logic [XW-1:0]        vga_x;
  logic [YW-1:0]        vga_y;
  logic [CW-1:0]        vga_colour;
  logic                 vga_plot;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: requested rectangles, RR pointer, last written pixel.
  int m_x [NREQ];
  int m_y [NREQ];
  int m_w [NREQ];
  int m_h [NREQ];
  int m_col [NREQ];
  int m_ptr;
  int m_hx, m_hy, m_hc;

  always #5 clk = ~clk;

  rect_fill_arbiter #(.NREQ(NREQ), .XW(XW), .YW(YW), .CW(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .rect_x      (rect_x),
    .rect_y      (rect_y),
    .rect_w      (rect_w),
    .rect_h      (rect_h),
    .rect_colour (rect_colour),
    .done        (done),
    .busy        (busy),
    .grant_id    (grant_id),
    .vga_x       (vga_x),
    .vga_y       (vga_y),
    .vga_colour  (vga_colour),
    .vga_plot    (vga_plot)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_rect(input int id, input int x, input int y, input int w, input int h, input int c);
    m_x[id] = x; m_y[id] = y; m_w[id] = w; m_h[id] = h; m_col[id] = c;
    rect_x[id*XW +: XW]      = XW'(x);
    rect_y[id*YW +: YW]      = YW'(y);
    rect_w[id*XW +: XW]      = XW'(w);
    rect_h[id*YW +: YW]      = YW'(h);
    rect_colour[id*CW +: CW] = CW'(c);
  endtask

  function automatic int model_pick(input logic [NREQ-1:0] pend, input int ptr);
    for (int i = 0; i < NREQ; i++) begin
      if (pend[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
    end
    return -1;
  endfunction

  // Follows one grant to requester id; done is expected on the lat-th falling edge.
  task automatic serve_one(input int id, input int lat, input bit perturb);
    int qx[$];
    int qy[$];
    int k, px, py;
    bit seen;
    logic [NREQ-1:0] exp_done;
    for (int cy = 0; cy < m_h[id]; cy++) begin
      for (int cx = 0; cx < m_w[id]; cx++) begin
        px = m_x[id] + cx;
        py = m_y[id] + cy;
`ifdef RECT_CLIP_EN
        if (px < SCREEN_W && py < SCREEN_H) begin
          qx.push_back(px);
          qy.push_back(py);
        end
`else
        qx.push_back(px % 256);
        qy.push_back(py % 256);
`endif
      end
    end
    exp_done     = '0;
    exp_done[id] = 1'b1;
    seen = 1'b0;
    k    = 0;
    while (!seen && k < lat + 4) begin
      @(negedge clk);
      k++;
      if (perturb && k == 6) begin
        rect_colour[id*CW +: CW] = ~CW'(m_col[id]);
        req[id] = 1'b0;
      end
      if (vga_plot) begin
        if (qx.size() == 0) begin
          check("extra_plot", 1, 0);
        end else begin
          check("plot_x", 32'(vga_x), qx[0]);
          check("plot_y", 32'(vga_y), qy[0]);
          check("plot_colour", 32'(vga_colour), m_col[id]);
          check("plot_grant", 32'(grant_id), id);
          check("plot_busy", 32'(busy), 1);
          m_hx = qx.pop_front();
          m_hy = qy.pop_front();
          m_hc = m_col[id];
        end
      end
      if (done != '0) begin
        seen = 1'b1;
        check("done_vec", 32'(done), 32'(exp_done));
        check("done_latency", k, lat);
        check("done_busy", 32'(busy), 1);
        check("done_grant", 32'(grant_id), id);
        check("missing_plots", qx.size(), 0);
        check("hold_x", 32'(vga_x), m_hx);
        check("hold_y", 32'(vga_y), m_hy);
        check("hold_colour", 32'(vga_colour), m_hc);
      end
    end
    if (!seen) check("done_timeout", 0, 1);
  endtask

  // Raises mask; keep=1 leaves served requesters asserted so they re-request.
  task automatic run_batch(input logic [NREQ-1:0] mask, input bit keep, input int n_serve, input bit perturb);
    logic [NREQ-1:0] pend;
    int lat_base, id;
    pend     = mask;
    lat_base = 3;
    @(posedge clk);
    #1 req = mask;
    for (int s = 0; s < n_serve; s++) begin
      id = model_pick(pend, m_ptr);
      if (id < 0) break;
      serve_one(id, lat_base + m_w[id] * m_h[id], perturb && s == 0);
      m_ptr = (id + 1) % NREQ;
      if (!keep) pend[id] = 1'b0;
      @(posedge clk);
      #1;
      if (!keep) req[id] = 1'b0;
      if (s == n_serve - 1) req = '0;
      @(negedge clk);
      check("done_single_pulse", 32'(done), 0);
      check("idle_busy", 32'(busy), 0);
      lat_base = 2;
    end
    req = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timed out");
  end

  initial begin
    logic [NREQ-1:0] rmask;
    rst = 1'b0;
    req = '0;
    rect_x = '0; rect_y = '0; rect_w = '0; rect_h = '0; rect_colour = '0;
    for (int i = 0; i < NREQ; i++) set_rect(i, 0, 0, 0, 0, 0);
    m_ptr = 0; m_hx = 0; m_hy = 0; m_hc = 0;

    #1;
    check("rst_plot", 32'(vga_plot), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_grant", 32'(grant_id), 0);
    check("rst_vga_x", 32'(vga_x), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Contention with all requests held: order 0,1,2,3,0.
    for (int i = 0; i < NREQ; i++) set_rect(i, i * 40, 10 + i, 3, 2, i + 1);
    run_batch(4'b1111, 1'b1, 5, 1'b0);

    // Single 2x16 request on requester 1.
    set_rect(1, 10, 52, 2, 16, 7);
    run_batch(4'b0010, 1'b0, 1, 1'b0);

    // Empty rectangle.
    set_rect(2, 30, 40, 0, 5, 3);
    run_batch(4'b0100, 1'b0, 1, 1'b0);

    // Corner rectangle that crosses the screen edge.
    set_rect(3, 158, 118, 4, 4, int'(COL_RED));
    run_batch(4'b1000, 1'b0, 1, 1'b0);

    // Inputs altered and req dropped mid-fill.
    set_rect(1, 50, 60, 4, 4, int'(COL_WHITE));
    run_batch(4'b0010, 1'b0, 1, 1'b1);

    for (int t = 0; t < 8; t++) begin
      int id;
      id = int'($urandom_range(0, NREQ - 1));
      set_rect(id, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
               int'($urandom_range(0, 10)), int'($urandom_range(0, 6)), int'($urandom_range(0, 7)));
      rmask = '0;
      rmask[id] = 1'b1;
      run_batch(rmask, 1'b0, 1, 1'b0);
    end

    for (int t = 0; t < 4; t++) begin
      rmask = NREQ'($urandom_range(1, 15));
      for (int i = 0; i < NREQ; i++)
        set_rect(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 6)), int'($urandom_range(0, 4)), int'($urandom_range(0, 7)));
      run_batch(rmask, 1'b0, $countones(rmask), 1'b0);
    end

    // Reset in the middle of an 8x8 fill.
    set_rect(3, 20, 30, 8, 8, int'(COL_RED));
    @(posedge clk);
    #1 req[3] = 1'b1;
    repeat (12) @(negedge clk);
    check("pre_rst_plot", 32'(vga_plot), 1);
    #1 rst = 1'b0;
    #1;
    check("mid_rst_plot", 32'(vga_plot), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_done", 32'(done), 0);
    check("mid_rst_vga_x", 32'(vga_x), 0);
    req = '0;
    m_ptr = 0; m_hx = 0; m_hy = 0; m_hc = 0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("post_rst_busy", 32'(busy), 0);

    // Pointer must have restarted at 0.
    for (int i = 0; i < NREQ; i++) set_rect(i, 100 + i, 20 * i, 2, 2, 7 - i);
    run_batch(4'b1111, 1'b0, 4, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
